// File: rtl/mmmm_io_black_box_if.sv
// Operand-load, launch/result handshake and result bus of the 8x8 systolic matrix-multiply engine.
// The engine takes the slave side; the operand supplier / result consumer takes the master side.
interface mmmm_io_black_box_if;
  logic        input_start;
  logic        input_valid;
  logic        input_ready;
  logic        output_ready;
  logic        output_valid;
  logic [31:0] sram_rdata_a0;
  logic [31:0] sram_rdata_a1;
  logic [31:0] sram_rdata_b0;
  logic [31:0] sram_rdata_b1;
  logic [9:0]  sram_raddr;
  logic [9:0]  sram_num;
  logic [63:0] c00, c01, c10, c11, c20, c21, c30, c31;
  logic [63:0] c40, c41, c50, c51, c60, c61, c70, c71;

  modport slave (
    input  input_start, input_valid, output_ready,
    input  sram_rdata_a0, sram_rdata_a1, sram_rdata_b0, sram_rdata_b1,
    input  sram_raddr, sram_num,
    output input_ready, output_valid,
    output c00, c01, c10, c11, c20, c21, c30, c31,
    output c40, c41, c50, c51, c60, c61, c70, c71
  );

  modport master (
    output input_start, input_valid, output_ready,
    output sram_rdata_a0, sram_rdata_a1, sram_rdata_b0, sram_rdata_b1,
    output sram_raddr, sram_num,
    input  input_ready, output_valid,
    input  c00, c01, c10, c11, c20, c21, c30, c31,
    input  c40, c41, c50, c51, c60, c61, c70, c71
  );
endinterface

// File: rtl/mmmm_io_black_box.sv
// Output-stationary 8x8 systolic matrix multiply (signed int8 in, int16 wrapping out) fed from
// NUM_SETS banks of pre-skewed operand streams; one bank is consumed per accepted launch.
module mmmm_io_black_box #(
  parameter int DATA_WIDTH     = 8,
  parameter int OUT_DATA_WIDTH = 16,
  parameter int ARRAY_SIZE     = 8,
  parameter int FEED_LEN       = 15,
  parameter int NUM_SETS       = 16
) (
  input  logic               clock,
  input  logic               reset,
  mmmm_io_black_box_if.slave io
);

  localparam int WORD_W         = ARRAY_SIZE * DATA_WIDTH;
  localparam int HALF_LANES     = ARRAY_SIZE / 2;
  localparam int HALF_W         = HALF_LANES * DATA_WIDTH;
  localparam int BANK_DEPTH     = 16;
  localparam int ADDR_W         = 4;
  localparam int SET_W          = $clog2(NUM_SETS);
  localparam int CYC_W          = 5;
  localparam int COMPUTE_CYCLES = FEED_LEN + 2 * (ARRAY_SIZE - 1) + 1;
  localparam int ROW_W          = ARRAY_SIZE * OUT_DATA_WIDTH;
  localparam int MEM_ROWS       = FEED_LEN;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_COMPUTE = 2'b01,
    ST_DONE    = 2'b10
  } state_e;

  state_e                            state_r;
  state_e                            state_nxt_s;
  logic                              launch_s;
  logic                              final_s;
  logic                              load_s;
  logic                              ready_r;
  logic                              valid_r;
  logic [SET_W-1:0]                  launch_cnt_r;
  logic [SET_W-1:0]                  bank_sel_r;
  logic [CYC_W-1:0]                  cyc_r;
  logic [SET_W-1:0]                  wr_bank_s;
  logic [ADDR_W-1:0]                 wr_addr_s;

  logic [WORD_W-1:0]                 a_bank_r [NUM_SETS][BANK_DEPTH];
  logic [WORD_W-1:0]                 b_bank_r [NUM_SETS][BANK_DEPTH];
  logic [WORD_W-1:0]                 feed_a_s;
  logic [WORD_W-1:0]                 feed_b_s;
  logic signed [DATA_WIDTH-1:0]      edge_a_s [ARRAY_SIZE];
  logic signed [DATA_WIDTH-1:0]      edge_b_s [ARRAY_SIZE];
  logic signed [DATA_WIDTH-1:0]      a_pipe_s [ARRAY_SIZE][ARRAY_SIZE];
  logic signed [DATA_WIDTH-1:0]      b_pipe_s [ARRAY_SIZE][ARRAY_SIZE];
  logic signed [OUT_DATA_WIDTH-1:0]  acc_s    [ARRAY_SIZE][ARRAY_SIZE];
  logic [ROW_W-1:0]                  row_s    [ARRAY_SIZE];
  logic [ROW_W-1:0]                  mem_c0_r [0:MEM_ROWS-1];

  // Lanes 0..3 sit in the low 32-bit half (lane 0 in its top byte); lanes 4..7 likewise in the high half.
  function automatic logic signed [DATA_WIDTH-1:0] lane_of(input logic [WORD_W-1:0] word, input int lane);
    int base;
    if (lane < HALF_LANES) begin
      base = (HALF_LANES - 32'sd1 - lane) * DATA_WIDTH;
    end else begin
      base = HALF_W + (ARRAY_SIZE - 32'sd1 - lane) * DATA_WIDTH;
    end
    return word[base +: DATA_WIDTH];
  endfunction

  assign wr_bank_s = io.sram_num[SET_W-1:0];
  assign wr_addr_s = io.sram_raddr[ADDR_W-1:0];
  assign load_s    = io.input_start && (state_r != ST_COMPUTE) &&
                     (io.sram_raddr < 10'(BANK_DEPTH)) && (io.sram_num < 10'(NUM_SETS));

  // Launch / run-length control
  always_comb begin
    state_nxt_s = state_r;
    launch_s    = 1'b0;
    final_s     = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (io.input_valid) begin
          launch_s    = 1'b1;
          state_nxt_s = ST_COMPUTE;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_COMPUTE: begin
        if (cyc_r == CYC_W'(COMPUTE_CYCLES - 1)) begin
          final_s     = 1'b1;
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_COMPUTE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Edge feed: stream words 0..FEED_LEN-1 of the selected bank, zeros while the array drains
  always_comb begin
    feed_a_s = '0;
    feed_b_s = '0;
    if ((state_r == ST_COMPUTE) && (cyc_r < CYC_W'(FEED_LEN))) begin
      feed_a_s = a_bank_r[bank_sel_r][cyc_r[ADDR_W-1:0]];
      feed_b_s = b_bank_r[bank_sel_r][cyc_r[ADDR_W-1:0]];
    end else begin
      feed_a_s = '0;
      feed_b_s = '0;
    end
    for (int l = 32'sd0; l < ARRAY_SIZE; l++) begin
      edge_a_s[l] = lane_of(feed_a_s, l);
      edge_b_s[l] = lane_of(feed_b_s, l);
    end
  end

  // Result rows, column 0 in the most significant slot
  always_comb begin
    for (int r = 32'sd0; r < ARRAY_SIZE; r++) begin
      row_s[r] = '0;
      for (int c = 32'sd0; c < ARRAY_SIZE; c++) begin
        row_s[r][(ARRAY_SIZE - 32'sd1 - c) * OUT_DATA_WIDTH +: OUT_DATA_WIDTH] = acc_s[r][c];
      end
    end
  end

  // Control registers and result capture
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      ready_r      <= 1'b1;
      valid_r      <= 1'b0;
      launch_cnt_r <= '0;
      bank_sel_r   <= '0;
      cyc_r        <= '0;
      for (int r = 32'sd0; r < MEM_ROWS; r++) begin
        mem_c0_r[r] <= '0;
      end
    end else begin
      state_r <= state_nxt_s;
      ready_r <= (state_nxt_s != ST_COMPUTE);
      valid_r <= (state_nxt_s == ST_DONE);
      if (launch_s) begin
        bank_sel_r   <= launch_cnt_r;
        launch_cnt_r <= (launch_cnt_r == SET_W'(NUM_SETS - 1)) ? '0 : launch_cnt_r + SET_W'(1);
        cyc_r        <= '0;
      end else if (state_r == ST_COMPUTE) begin
        cyc_r <= cyc_r + CYC_W'(1);
      end
      if (final_s) begin
        for (int r = 32'sd0; r < MEM_ROWS; r++) begin
          mem_c0_r[r] <= (r < ARRAY_SIZE) ? row_s[r] : '0;
        end
      end
    end
  end

  // Operand banks; writes to out-of-range words or banks are dropped
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int s = 32'sd0; s < NUM_SETS; s++) begin
        for (int w = 32'sd0; w < BANK_DEPTH; w++) begin
          a_bank_r[s][w] <= '0;
          b_bank_r[s][w] <= '0;
        end
      end
    end else if (load_s) begin
      a_bank_r[wr_bank_s][wr_addr_s] <= {io.sram_rdata_a1, io.sram_rdata_a0};
      b_bank_r[wr_bank_s][wr_addr_s] <= {io.sram_rdata_b1, io.sram_rdata_b0};
    end
  end

  for (genvar gi = 0; gi < ARRAY_SIZE; gi++) begin : g_row
    for (genvar gj = 0; gj < ARRAY_SIZE; gj++) begin : g_col
      logic signed [DATA_WIDTH-1:0]     a_in_s;
      logic signed [DATA_WIDTH-1:0]     b_in_s;
      logic signed [DATA_WIDTH-1:0]     a_r;
      logic signed [DATA_WIDTH-1:0]     b_r;
      logic signed [OUT_DATA_WIDTH-1:0] prod_s;
      logic signed [OUT_DATA_WIDTH-1:0] acc_r;

      if (gj == 0) begin : g_a_edge
        assign a_in_s = edge_a_s[gi];
      end else begin : g_a_pass
        assign a_in_s = a_pipe_s[gi][gj-1];
      end
      if (gi == 0) begin : g_b_edge
        assign b_in_s = edge_b_s[gj];
      end else begin : g_b_pass
        assign b_in_s = b_pipe_s[gi-1][gj];
      end

      assign prod_s         = OUT_DATA_WIDTH'(a_in_s) * OUT_DATA_WIDTH'(b_in_s);
      assign a_pipe_s[gi][gj] = a_r;
      assign b_pipe_s[gi][gj] = b_r;
      assign acc_s[gi][gj]    = acc_r;

      // Multiply-accumulate and forward operands one hop right/down
      always_ff @(posedge clock) begin
        if (reset) begin
          a_r   <= '0;
          b_r   <= '0;
          acc_r <= '0;
        end else if (launch_s) begin
          a_r   <= '0;
          b_r   <= '0;
          acc_r <= '0;
        end else if (state_r == ST_COMPUTE) begin
          a_r   <= a_in_s;
          b_r   <= b_in_s;
          acc_r <= acc_r + prod_s;
        end
      end
    end
  end

  assign io.input_ready  = ready_r;
  assign io.output_valid = valid_r;
  assign io.c00 = mem_c0_r[0][ROW_W-1:ROW_W/2];
  assign io.c01 = mem_c0_r[0][ROW_W/2-1:0];
  assign io.c10 = mem_c0_r[1][ROW_W-1:ROW_W/2];
  assign io.c11 = mem_c0_r[1][ROW_W/2-1:0];
  assign io.c20 = mem_c0_r[2][ROW_W-1:ROW_W/2];
  assign io.c21 = mem_c0_r[2][ROW_W/2-1:0];
  assign io.c30 = mem_c0_r[3][ROW_W-1:ROW_W/2];
  assign io.c31 = mem_c0_r[3][ROW_W/2-1:0];
  assign io.c40 = mem_c0_r[4][ROW_W-1:ROW_W/2];
  assign io.c41 = mem_c0_r[4][ROW_W/2-1:0];
  assign io.c50 = mem_c0_r[5][ROW_W-1:ROW_W/2];
  assign io.c51 = mem_c0_r[5][ROW_W/2-1:0];
  assign io.c60 = mem_c0_r[6][ROW_W-1:ROW_W/2];
  assign io.c61 = mem_c0_r[6][ROW_W/2-1:0];
  assign io.c70 = mem_c0_r[7][ROW_W-1:ROW_W/2];
  assign io.c71 = mem_c0_r[7][ROW_W/2-1:0];

endmodule

// File: tb/tb_mmmm_io_black_box.sv
// Self-checking bench: banks hold whole A/B matrices in the model; expected C is a plain
// triple-loop product wrapped to 16 bits, and stream words are generated from the skew rule.
module tb_mmmm_io_black_box;
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  mmmm_io_black_box_if io();
  mmmm_io_black_box dut (.clock(clock), .reset(reset), .io(io));

  typedef struct {
    int          a_fill;
    int          b_fill;
    logic [15:0] exp_elem;
  } vec_t;

  int tests = 0;
  int fails = 0;
  int launch_cnt = 0;
  int model_a [16][8][8];
  int model_b [16][8][8];
  int exp_c [8][8];
  vec_t vecs [6];
  logic [127:0] row_v [8];

  assign row_v[0] = {io.c00, io.c01};
  assign row_v[1] = {io.c10, io.c11};
  assign row_v[2] = {io.c20, io.c21};
  assign row_v[3] = {io.c30, io.c31};
  assign row_v[4] = {io.c40, io.c41};
  assign row_v[5] = {io.c50, io.c51};
  assign row_v[6] = {io.c60, io.c61};
  assign row_v[7] = {io.c70, io.c71};

  function automatic logic [15:0] dut_c(input int r, input int c);
    logic [127:0] row;
    row = row_v[r];
    return row[127 - 16*c -: 16];
  endfunction

  function automatic int lane_pos(input int lane);
    return (lane < 4) ? 24 - 8*lane : 56 - 8*(lane - 4);
  endfunction

  // word t, A lane i = A[i][t-i]
  function automatic logic [63:0] a_word(input int bank, input int t);
    logic [63:0] w;
    int k;
    w = '0;
    for (int i = 0; i < 8; i++) begin
      k = t - i;
      if (k >= 0 && k < 8) w[lane_pos(i) +: 8] = 8'(model_a[bank][i][k]);
    end
    return w;
  endfunction

  // word t, B lane j = B[t-j][j]
  function automatic logic [63:0] b_word(input int bank, input int t);
    logic [63:0] w;
    int k;
    w = '0;
    for (int j = 0; j < 8; j++) begin
      k = t - j;
      if (k >= 0 && k < 8) w[lane_pos(j) +: 8] = 8'(model_b[bank][k][j]);
    end
    return w;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic check_matrix(input string name);
    bit bad;
    int br, bc;
    logic [15:0] got, want, bg, bw;
    bad = 1'b0; br = 0; bc = 0; bg = '0; bw = '0;
    tests++;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        got  = dut_c(r, c);
        want = 16'(exp_c[r][c]);
        if (!bad && got !== want) begin
          bad = 1'b1; br = r; bc = c; bg = got; bw = want;
        end
      end
    end
    if (bad) begin
      fails++;
      $display("FAIL %s: C[%0d][%0d] got %h, required %h", name, br, bc, bg, bw);
    end
  endtask

  task automatic compute_expected(input int bank);
    int s;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        s = 0;
        for (int k = 0; k < 8; k++) s += model_a[bank][r][k] * model_b[bank][k][c];
        exp_c[r][c] = s;
      end
    end
  endtask

  task automatic fill_random(input int bank);
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        model_a[bank][r][c] = int'($urandom_range(255)) - 128;
        model_b[bank][r][c] = int'($urandom_range(255)) - 128;
      end
    end
  endtask

  task automatic fill_uniform(input int bank, input int av, input int bv);
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        model_a[bank][r][c] = av;
        model_b[bank][r][c] = bv;
      end
    end
  endtask

  task automatic write_word(input int bank, input int addr, input logic [63:0] aw, input logic [63:0] bw);
    @(negedge clock);
    io.input_start = 1'b1;
    io.sram_num    = 10'(bank);
    io.sram_raddr  = 10'(addr);
    {io.sram_rdata_a1, io.sram_rdata_a0} = aw;
    {io.sram_rdata_b1, io.sram_rdata_b0} = bw;
    @(posedge clock);
    #1 io.input_start = 1'b0;
  endtask

  task automatic load_bank(input int bank);
    for (int t = 0; t < 15; t++) write_word(bank, t, a_word(bank, t), b_word(bank, t));
    write_word(bank, 15, {$urandom, $urandom}, {$urandom, $urandom});
  endtask

  task automatic launch(input string name, input bit poke_mid);
    int lat;
    @(negedge clock);
    io.input_valid = 1'b1;
    @(posedge clock);
    #1 io.input_valid = 1'b0;
    launch_cnt = (launch_cnt + 1) % 16;
    check({name, "_ready_low"}, 64'(io.input_ready), 64'd0);
    lat = 0;
    while (io.output_valid !== 1'b1 && lat < 40) begin
      io.input_valid = (poke_mid && lat == 10);
      @(posedge clock);
      #1 lat++;
    end
    io.input_valid = 1'b0;
    check({name, "_latency"}, 64'(lat), 64'd30);
  endtask

  task automatic check_zero_outputs(input string name);
    logic [63:0] any;
    any = '0;
    for (int r = 0; r < 8; r++) any |= row_v[r][127:64] | row_v[r][63:0];
    check({name, "_ready"}, 64'(io.input_ready), 64'd1);
    check({name, "_valid"}, 64'(io.output_valid), 64'd0);
    check({name, "_c_zero"}, any, 64'd0);
  endtask

  initial begin
    int bank;
    vecs[0] = '{127, 127, 16'hF808};
    vecs[1] = '{1, -1, 16'hFFF8};
    vecs[2] = '{-128, 127, 16'h0400};
    vecs[3] = '{-128, -128, 16'h0000};
    vecs[4] = '{0, 55, 16'h0000};
    vecs[5] = '{3, -7, 16'hFF58};
    for (int b = 0; b < 16; b++) fill_uniform(b, 0, 0);

    reset = 1'b1;
    io.input_start = 1'b0; io.input_valid = 1'b0; io.output_ready = 1'b0;
    io.sram_rdata_a0 = '0; io.sram_rdata_a1 = '0; io.sram_rdata_b0 = '0; io.sram_rdata_b1 = '0;
    io.sram_raddr = '0; io.sram_num = '0;
    repeat (3) @(posedge clock);
    @(negedge clock) reset = 1'b0;
    repeat (2) @(posedge clock);
    #1 check_zero_outputs("reset");

    // Directed: identity A, sparse B -> C equals B
    for (int i = 0; i < 8; i++) model_a[0][i][i] = 1;
    model_b[0][0][0] = 99; model_b[0][1][0] = -48; model_b[0][0][1] = -93;
    load_bank(0);
    launch("ident", 1'b0);
    check("ident_c00", 64'(dut_c(0, 0)), 64'h0063);
    check("ident_c01", 64'(dut_c(0, 1)), 64'hFFA3);
    check("ident_c10", 64'(dut_c(1, 0)), 64'hFFD0);
    compute_expected(0);
    check_matrix("ident_c_eq_b");

    // Loads and consumer handshakes while DONE must not disturb held results
    fill_random(1);
    load_bank(1);
    write_word(1, 19, {$urandom, $urandom}, {$urandom, $urandom});
    write_word(17, 3, {$urandom, $urandom}, {$urandom, $urandom});
    write_word(33, 5, {$urandom, $urandom}, {$urandom, $urandom});
    write_word(1, 1023, {$urandom, $urandom}, {$urandom, $urandom});
    io.output_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1 io.output_ready = 1'b0;
    check("done_valid_held", 64'(io.output_valid), 64'd1);
    check("done_ready", 64'(io.input_ready), 64'd1);
    check_matrix("done_result_held");

    launch("bank1_drop", 1'b0);
    compute_expected(1);
    check_matrix("bank1_drop");

    // Table: uniform fills with known wrapped sums
    for (int v = 0; v < 6; v++) begin
      bank = launch_cnt;
      fill_uniform(bank, vecs[v].a_fill, vecs[v].b_fill);
      load_bank(bank);
      launch($sformatf("uniform%0d", v), 1'b0);
      for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) exp_c[r][c] = int'(vecs[v].exp_elem);
      check_matrix($sformatf("uniform%0d", v));
    end

    // Ten random banks preloaded, then launched 50 cycles apart (crosses the bank wrap)
    for (int k = 0; k < 10; k++) begin
      fill_random((launch_cnt + k) % 16);
      load_bank((launch_cnt + k) % 16);
    end
    for (int k = 0; k < 10; k++) begin
      bank = launch_cnt;
      launch($sformatf("rand%0d", k), k[0]);
      compute_expected(bank);
      check_matrix($sformatf("rand%0d", k));
      repeat (20) @(posedge clock);
    end

    // Reset in the middle of a run
    bank = launch_cnt;
    fill_random(bank);
    load_bank(bank);
    @(negedge clock) io.input_valid = 1'b1;
    @(posedge clock);
    #1 io.input_valid = 1'b0;
    repeat (12) @(posedge clock);
    @(negedge clock) reset = 1'b1;
    @(posedge clock);
    #1 check_zero_outputs("mid_reset");
    @(negedge clock) reset = 1'b0;
    launch_cnt = 0;
    for (int b = 0; b < 16; b++) fill_uniform(b, 0, 0);

    // Banks were cleared: bank 0 yields zeros
    launch("post_reset_bank0", 1'b0);
    compute_expected(0);
    check_matrix("post_reset_bank0");

    // Counter restarted: next launch takes bank 1, not bank 0
    fill_random(0);
    load_bank(0);
    fill_random(1);
    load_bank(1);
    launch("post_reset_bank1", 1'b0);
    compute_expected(1);
    check_matrix("post_reset_bank1");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
